// File: rtl/window_accumulator.sv
// window_accumulator
//   Accumulates NUM_LINES per-line sums (image squared, image, and one
//   template-product sum per template) into window totals. Each window is
//   presented once on a valid/ready output handshake.
//
//   Optional feature macro: WINDOW_BEST_MATCH_EN
//     defined   -> best_idx/best_sum hold the argmax of the window template sums
//     undefined -> best_idx/best_sum are tied to 0
//
// Ports
//   CLK, RST_N          clock, synchronous active-low reset
//   clear               synchronous abort of the current window
//   in_valid/in_ready   line-sum input handshake
//   I_square_line_sum   sum of squared pixels of one line      (SUM_W)
//   I_line_sum          sum of pixels of one line              (SUM_W)
//   T_x_I_line_sums     per-template line product sums         (NUM_TEMPLATES x SUM_W)
//   out_valid/out_ready window result handshake
//   I_square_win_sum    window total of I_square_line_sum      (ACC_W)
//   I_win_sum           window total of I_line_sum             (ACC_W)
//   T_x_I_win_sums      per-template window totals             (NUM_TEMPLATES x ACC_W)
//   best_idx, best_sum  index and value of the largest template total
module window_accumulator #(
  parameter  int unsigned PIXEL_SIZE    = 8,
  parameter  int unsigned LINE_SIZE     = 16,
  parameter  int unsigned NUM_TEMPLATES = 4,
  parameter  int unsigned NUM_LINES     = 16,
  localparam int unsigned SUM_W         = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE,
  localparam int unsigned ACC_W         = SUM_W + $clog2(NUM_LINES),
  localparam int unsigned IDX_W         = (NUM_TEMPLATES > 1) ? $clog2(NUM_TEMPLATES) : 1
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             clear,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SUM_W-1:0]                 I_square_line_sum,
  input  logic [SUM_W-1:0]                 I_line_sum,
  input  logic [NUM_TEMPLATES*SUM_W-1:0]   T_x_I_line_sums,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_W-1:0]                 I_square_win_sum,
  output logic [ACC_W-1:0]                 I_win_sum,
  output logic [NUM_TEMPLATES*ACC_W-1:0]   T_x_I_win_sums,
  output logic [IDX_W-1:0]                 best_idx,
  output logic [ACC_W-1:0]                 best_sum
);

  localparam int unsigned CNT_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ACCUM = 2'b01;
  localparam logic [1:0] ST_HOLD  = 2'b10;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_line_cnt;
  logic [CNT_W-1:0] w_line_cnt_nxt;
  logic             r_out_valid;
  logic             w_out_valid_nxt;
  logic             r_in_ready;

  logic             w_beat;
  logic             w_acc_we;
  logic             w_load_out;

  logic [ACC_W-1:0] r_acc_sq;
  logic [ACC_W-1:0] r_acc_i;
  logic [ACC_W-1:0] r_acc_t [NUM_TEMPLATES];
  logic [ACC_W-1:0] w_tot_sq;
  logic [ACC_W-1:0] w_tot_i;
  logic [ACC_W-1:0] w_tot_t [NUM_TEMPLATES];

  logic [ACC_W-1:0] r_out_sq;
  logic [ACC_W-1:0] r_out_i;
  logic [ACC_W-1:0] r_out_t [NUM_TEMPLATES];

  // clear discards any beat presented in the same cycle
  assign w_beat = in_valid && r_in_ready && !clear;

  // Running totals including the current input; the first line of a window
  // starts from zero so no residue of the previous window survives.
  always_comb begin : p_totals
    w_tot_sq = ((r_state == ST_IDLE) ? '0 : r_acc_sq) + ACC_W'(I_square_line_sum);
    w_tot_i  = ((r_state == ST_IDLE) ? '0 : r_acc_i)  + ACC_W'(I_line_sum);
    for (int k = 0; k < NUM_TEMPLATES; k++) begin
      w_tot_t[k] = ((r_state == ST_IDLE) ? '0 : r_acc_t[k])
                 + ACC_W'(T_x_I_line_sums[k*SUM_W +: SUM_W]);
    end
  end

  // Next-state and control decode
  always_comb begin : p_next
    w_state_nxt     = r_state;
    w_line_cnt_nxt  = r_line_cnt;
    w_out_valid_nxt = r_out_valid;
    w_acc_we        = 1'b0;
    w_load_out      = 1'b0;
    if (clear) begin
      w_state_nxt     = ST_IDLE;
      w_line_cnt_nxt  = '0;
      w_out_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (w_beat) begin
            if (r_line_cnt == CNT_W'(NUM_LINES - 1)) begin
              w_load_out      = 1'b1;
              w_out_valid_nxt = 1'b1;
              w_line_cnt_nxt  = '0;
              w_state_nxt     = ST_HOLD;
            end else begin
              w_acc_we       = 1'b1;
              w_line_cnt_nxt = r_line_cnt + CNT_W'(1);
              w_state_nxt    = ST_ACCUM;
            end
          end
        end
        ST_HOLD: begin
          if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
            w_line_cnt_nxt  = '0;
            w_state_nxt     = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt     = ST_IDLE;
          w_line_cnt_nxt  = '0;
          w_out_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State, handshake and datapath registers
  always_ff @(posedge CLK) begin : p_regs
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_line_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_acc_sq    <= '0;
      r_acc_i     <= '0;
      r_out_sq    <= '0;
      r_out_i     <= '0;
      for (int k = 0; k < NUM_TEMPLATES; k++) begin
        r_acc_t[k] <= '0;
        r_out_t[k] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_line_cnt  <= w_line_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= (w_state_nxt != ST_HOLD);
      if (w_acc_we) begin
        r_acc_sq <= w_tot_sq;
        r_acc_i  <= w_tot_i;
        for (int k = 0; k < NUM_TEMPLATES; k++) r_acc_t[k] <= w_tot_t[k];
      end
      if (w_load_out) begin
        r_out_sq <= w_tot_sq;
        r_out_i  <= w_tot_i;
        for (int k = 0; k < NUM_TEMPLATES; k++) r_out_t[k] <= w_tot_t[k];
      end
    end
  end

  assign in_ready         = r_in_ready;
  assign out_valid        = r_out_valid;
  assign I_square_win_sum = r_out_sq;
  assign I_win_sum        = r_out_i;

  for (genvar g = 0; g < NUM_TEMPLATES; g++) begin : g_out_t
    assign T_x_I_win_sums[g*ACC_W +: ACC_W] = r_out_t[g];
  end

`ifdef WINDOW_BEST_MATCH_EN
  logic [IDX_W-1:0] w_best_idx;
  logic [ACC_W-1:0] w_best_sum;
  logic [IDX_W-1:0] r_best_idx;
  logic [ACC_W-1:0] r_best_sum;

  // Argmax over final totals; strict compare keeps the lowest index on ties
  always_comb begin : p_argmax
    w_best_idx = '0;
    w_best_sum = w_tot_t[0];
    for (int k = 1; k < NUM_TEMPLATES; k++) begin
      if (w_tot_t[k] > w_best_sum) begin
        w_best_idx = IDX_W'(k);
        w_best_sum = w_tot_t[k];
      end
    end
  end

  always_ff @(posedge CLK) begin : p_best
    if (!RST_N) begin
      r_best_idx <= '0;
      r_best_sum <= '0;
    end else if (w_load_out) begin
      r_best_idx <= w_best_idx;
      r_best_sum <= w_best_sum;
    end
  end

  assign best_idx = r_best_idx;
  assign best_sum = r_best_sum;
`else
  assign best_idx = '0;
  assign best_sum = '0;
`endif

endmodule

// File: tb/tb_window_accumulator.sv
// Directed self-checking bench for window_accumulator
// (PIXEL_SIZE=8, LINE_SIZE=4, NUM_TEMPLATES=2, NUM_LINES=3).
module tb_window_accumulator;

  localparam int unsigned PIXEL_SIZE    = 8;
  localparam int unsigned LINE_SIZE     = 4;
  localparam int unsigned NUM_TEMPLATES = 2;
  localparam int unsigned NUM_LINES     = 3;
  localparam int unsigned SUM_W         = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
  localparam int unsigned ACC_W         = SUM_W + $clog2(NUM_LINES);
  localparam int unsigned IDX_W         = 1;
  localparam int unsigned TOT_W         = (2 + NUM_TEMPLATES) * ACC_W;

  logic                           CLK;
  logic                           RST_N;
  logic                           clear;
  logic                           in_valid;
  logic                           in_ready;
  logic [SUM_W-1:0]               I_square_line_sum;
  logic [SUM_W-1:0]               I_line_sum;
  logic [NUM_TEMPLATES*SUM_W-1:0] T_x_I_line_sums;
  logic                           out_valid;
  logic                           out_ready;
  logic [ACC_W-1:0]               I_square_win_sum;
  logic [ACC_W-1:0]               I_win_sum;
  logic [NUM_TEMPLATES*ACC_W-1:0] T_x_I_win_sums;
  logic [IDX_W-1:0]               best_idx;
  logic [ACC_W-1:0]               best_sum;

  int total = 0;
  int bad   = 0;

  logic [TOT_W-1:0] obs_tot;
  logic [TOT_W-1:0] exp_tot;
  logic [IDX_W-1:0] exp_idx;
  logic [ACC_W-1:0] exp_best;

  window_accumulator #(
    .PIXEL_SIZE    (PIXEL_SIZE),
    .LINE_SIZE     (LINE_SIZE),
    .NUM_TEMPLATES (NUM_TEMPLATES),
    .NUM_LINES     (NUM_LINES)
  ) dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .clear             (clear),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .I_square_line_sum (I_square_line_sum),
    .I_line_sum        (I_line_sum),
    .T_x_I_line_sums   (T_x_I_line_sums),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .I_square_win_sum  (I_square_win_sum),
    .I_win_sum         (I_win_sum),
    .T_x_I_win_sums    (T_x_I_win_sums),
    .best_idx          (best_idx),
    .best_sum          (best_sum)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign obs_tot = {I_square_win_sum, I_win_sum, T_x_I_win_sums};

  // Advance one clock; sample point is 1 time unit after the rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present one beat for exactly one edge
  task automatic drive_beat(input logic [SUM_W-1:0] sq, input logic [SUM_W-1:0] s,
                            input logic [SUM_W-1:0] t0, input logic [SUM_W-1:0] t1);
    in_valid          = 1'b1;
    I_square_line_sum = sq;
    I_line_sum        = s;
    T_x_I_line_sums   = {t1, t0};
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    step();
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready);
    end
    total++;
    if (obs_tot !== '0) begin
      bad++; $display("FAIL reset_totals got=%0h want=0", obs_tot);
    end
    total++;
    if ({best_idx, best_sum} !== '0) begin
      bad++; $display("FAIL reset_best got=%0d/%0d want=0/0", best_idx, best_sum);
    end
    RST_N = 1'b1;
  endtask

  task automatic test_basic();
    drive_beat(10, 1, 5, 7);
    drive_beat(20, 2, 5, 7);
    drive_beat(30, 3, 5, 7);
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL basic_out_valid got=%0b want=1", out_valid);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL basic_in_ready got=%0b want=0", in_ready);
    end
    exp_tot = {ACC_W'(60), ACC_W'(6), ACC_W'(21), ACC_W'(15)};
    total++;
    if (obs_tot !== exp_tot) begin
      bad++; $display("FAIL basic_totals got=%0h want=%0h", obs_tot, exp_tot);
    end
`ifdef WINDOW_BEST_MATCH_EN
    exp_idx = 1'b1; exp_best = ACC_W'(21);
`else
    exp_idx = '0;   exp_best = '0;
`endif
    total++;
    if ({best_idx, best_sum} !== {exp_idx, exp_best}) begin
      bad++; $display("FAIL basic_best got=%0d/%0d want=%0d/%0d", best_idx, best_sum, exp_idx, exp_best);
    end
  endtask

  task automatic test_back_pressure();
    out_ready         = 1'b0;
    in_valid          = 1'b1;
    I_square_line_sum = 99;
    I_line_sum        = 99;
    T_x_I_line_sums   = {SUM_W'(99), SUM_W'(99)};
    exp_tot = {ACC_W'(60), ACC_W'(6), ACC_W'(21), ACC_W'(15)};
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if ({out_valid, in_ready} !== 2'b10) begin
        bad++; $display("FAIL hold_handshake cyc=%0d got=%0b%0b want=10", c, out_valid, in_ready);
      end
      total++;
      if (obs_tot !== exp_tot) begin
        bad++; $display("FAIL hold_totals cyc=%0d got=%0h want=%0h", c, obs_tot, exp_tot);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL release_handshake got=%0b%0b want=01", out_valid, in_ready);
    end
  endtask

  task automatic test_reload();
    drive_beat(1, 1, 1, 1);
    drive_beat(1, 1, 1, 1);
    drive_beat(1, 1, 1, 1);
    exp_tot = {ACC_W'(3), ACC_W'(3), ACC_W'(3), ACC_W'(3)};
    total++;
    if ({out_valid, obs_tot} !== {1'b1, exp_tot}) begin
      bad++; $display("FAIL reload_totals got=%0b/%0h want=1/%0h", out_valid, obs_tot, exp_tot);
    end
`ifdef WINDOW_BEST_MATCH_EN
    exp_idx = '0; exp_best = ACC_W'(3);
`else
    exp_idx = '0; exp_best = '0;
`endif
    total++;
    if ({best_idx, best_sum} !== {exp_idx, exp_best}) begin
      bad++; $display("FAIL reload_best got=%0d/%0d want=%0d/%0d", best_idx, best_sum, exp_idx, exp_best);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_clear();
    drive_beat(100, 100, 100, 100);
    drive_beat(100, 100, 100, 100);
    clear = 1'b1;
    drive_beat(100, 100, 100, 100);
    clear = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL clear_state got=%0b%0b want=01", out_valid, in_ready);
    end
    drive_beat(1, 1, 1, 1);
    drive_beat(1, 1, 1, 1);
    drive_beat(1, 1, 1, 1);
    exp_tot = {ACC_W'(3), ACC_W'(3), ACC_W'(3), ACC_W'(3)};
    total++;
    if ({out_valid, obs_tot} !== {1'b1, exp_tot}) begin
      bad++; $display("FAIL clear_totals got=%0b/%0h want=1/%0h", out_valid, obs_tot, exp_tot);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_in_hold();
    drive_beat(5, 5, 5, 9);
    drive_beat(5, 5, 5, 9);
    drive_beat(5, 5, 5, 9);
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL rst_hold_pre got=%0b want=1", out_valid);
    end
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL rst_hold_handshake got=%0b%0b want=01", out_valid, in_ready);
    end
    total++;
    if ({obs_tot, best_idx, best_sum} !== '0) begin
      bad++; $display("FAIL rst_hold_outputs got=%0h/%0d/%0d want=0", obs_tot, best_idx, best_sum);
    end
  endtask

  task automatic test_max_values();
    logic [SUM_W-1:0] m;
    logic [ACC_W-1:0] m3;
    m  = '1;
    m3 = ACC_W'(m) + ACC_W'(m) + ACC_W'(m);
    drive_beat(m, m, m, m);
    drive_beat(m, m, m, m);
    drive_beat(m, m, m, m);
    exp_tot = {m3, m3, m3, m3};
    total++;
    if ({out_valid, obs_tot} !== {1'b1, exp_tot}) begin
      bad++; $display("FAIL max_totals got=%0b/%0h want=1/%0h", out_valid, obs_tot, exp_tot);
    end
`ifdef WINDOW_BEST_MATCH_EN
    exp_idx = '0; exp_best = m3;
`else
    exp_idx = '0; exp_best = '0;
`endif
    total++;
    if ({best_idx, best_sum} !== {exp_idx, exp_best}) begin
      bad++; $display("FAIL max_best got=%0d/%0d want=%0d/%0d", best_idx, best_sum, exp_idx, exp_best);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL max_release got=%0b%0b want=01", out_valid, in_ready);
    end
  endtask

  initial begin
    RST_N             = 1'b0;
    clear             = 1'b0;
    in_valid          = 1'b0;
    out_ready         = 1'b0;
    I_square_line_sum = '0;
    I_line_sum        = '0;
    T_x_I_line_sums   = '0;
    exp_tot           = '0;
    exp_idx           = '0;
    exp_best          = '0;
    test_reset();
    test_basic();
    test_back_pressure();
    test_reload();
    test_clear();
    test_reset_in_hold();
    test_max_values();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_accumulator.md
WINDOW_ACCUMULATOR -- requirements
Module: window_accumulator

Interface
REQ-001 SHALL have parameter PIXEL_SIZE, default 8: pixel width in bits.
REQ-002 SHALL have parameter LINE_SIZE, default 16: pixels per template line.
REQ-003 SHALL have parameter NUM_TEMPLATES, default 4: number of templates correlated in parallel.
REQ-004 SHALL have parameter NUM_LINES, default 16: template height, i.e. line sums per window.
REQ-005 SHALL have parameters that derive SUM_W = $clog2(LINE_SIZE)+2*PIXEL_SIZE and ACC_W = SUM_W+$clog2(NUM_LINES).
REQ-006 SHALL have one clock; reset is synchronous and active-low.
REQ-007 SHALL have port CLK  in  1: the only clock; all state updates on its rising edge.
REQ-008 SHALL have port RST_N  in  1: synchronous active-low reset.
REQ-009 SHALL have port clear  in  1: synchronous abort of the current window.
REQ-010 SHALL have port in_valid  in  1: the line sums are valid this cycle.
REQ-011 SHALL have port in_ready  out  1: the block accepts line sums this cycle.
REQ-012 SHALL have port I_square_line_sum  in  SUM_W: sum of squared image pixels of one line.
REQ-013 SHALL have port I_line_sum  in  SUM_W: sum of image pixels of one line.
REQ-014 SHALL have port T_x_I_line_sums  in  SUM_W x NUM_TEMPLATES: per-template line products sum.
REQ-015 SHALL have port out_valid  out  1: the window results are valid.
REQ-016 SHALL have port out_ready  in  1: the consumer accepts the results.
REQ-017 SHALL have ports I_square_win_sum and I_win_sum  out  ACC_W each: window totals.
REQ-018 SHALL have port T_x_I_win_sums  out  ACC_W x NUM_TEMPLATES: per-template window totals.
REQ-019 SHALL have port best_idx  out  $clog2(NUM_TEMPLATES): template with the largest T_x_I_win_sum.
REQ-020 SHALL have port best_sum  out  ACC_W: value of that largest sum.

Function
REQ-021 SHALL define an input beat accepted as in_valid && in_ready on a rising edge.
REQ-022 SHALL implement states IDLE, ACCUM and HOLD; in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-023 SHALL track a line counter line_cnt, 0..NUM_LINES-1; each accepted beat increments it, and it wraps to 0 after NUM_LINES-1.
REQ-024 SHALL, for a beat accepted in IDLE (line_cnt==0), load the accumulators with the inputs, not add them, and go to ACCUM; when NUM_LINES==1, go straight to HOLD.
REQ-025 SHALL, for a beat accepted in ACCUM, add the inputs (zero-extended, unsigned) to the accumulators.
REQ-026 SHALL, on the beat with line_cnt==NUM_LINES-1, register the final totals (accumulator plus current input) to the outputs, set out_valid=1 on the next cycle and enter HOLD; latency is 1 cycle from the last accepted beat to out_valid.
REQ-027 SHALL never overflow: ACC_W holds NUM_LINES maximum SUM_W values exactly.
REQ-028 SHALL, in HOLD, keep all outputs stable until out_valid && out_ready; the next cycle SHALL then have out_valid=0, line_cnt=0, state IDLE and in_ready=1.
REQ-029 SHALL ignore in_valid while in HOLD, and SHALL lose no data, because in_ready=0.
REQ-030 SHALL treat clear=1 as highest priority below reset: line_cnt=0, state IDLE, out_valid=0, and any beat in that cycle discarded; output data registers keep their values.
REQ-031 SHALL process back-to-back beats with no bubbles within a window; the only bubble between windows is the HOLD handshake, minimum 1 cycle.

Reset
REQ-032 SHALL, with RST_N=0 at a rising edge, set state IDLE, line_cnt=0, out_valid=0, in_ready=1 on the next cycle, and clear all accumulators, sum outputs, best_idx and best_sum to 0.
REQ-033 SHALL abandon a partial window on reset mid-window or in HOLD, with no output produced.

Configuration
REQ-034 SHALL use macro WINDOW_BEST_MATCH_EN. When defined, best_idx/best_sum are registered together with the window totals as the argmax of the final T_x_I_win_sums (unsigned compare, ties resolved to the lowest index). When undefined, best_idx and best_sum are constant 0 and no comparator logic exists; all other behaviour is identical.

Verification
REQ-035 SHALL test with bench parameters PIXEL_SIZE=8, LINE_SIZE=4, NUM_TEMPLATES=2, NUM_LINES=3.
REQ-036 SHALL cover basic window: beats (I²,I,T0,T1)=(10,1,5,7),(20,2,5,7),(30,3,5,7) on consecutive cycles -> 1 cycle later out_valid=1 with 60,6,15,21; best_idx=1, best_sum=21.
REQ-037 SHALL cover back-pressure: hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0; out_ready=1 -> next cycle out_valid=0, in_ready=1.
REQ-038 SHALL cover reload: a second window of all-ones beats after the first -> totals 3,3,3,3 with no residue of window 1; tie gives best_idx=0.
REQ-039 SHALL cover clear: two beats, then clear=1 with in_valid=1 -> beat dropped; three new beats of value 1 -> totals 3.
REQ-040 SHALL cover reset: RST_N=0 during HOLD -> out_valid=0 and all outputs 0 next cycle.
REQ-041 SHALL cover maximum values: every input at 2^SUM_W-1 -> totals 3*(2^SUM_W-1) exact; repeat with WINDOW_BEST_MATCH_EN undefined -> best_idx=best_sum=0.
